// File: rtl/trap_arbiter_pkg.sv
// trap_arbiter_pkg: shared types and the ROB age comparison for the trap arbiter.
package trap_arbiter_pkg;
  localparam int ROB_SIZE  = 32;
  localparam int ROB_W     = $clog2(ROB_SIZE);
  localparam int FTQ_W     = 6;
  localparam int FTQ_OFF_W = 4;

  typedef struct packed {
    logic             flipped;
    logic [ROB_W-1:0] idx;
  } robIdx_t;

  typedef logic [FTQ_W-1:0]     ftqIdx_t;
  typedef logic [FTQ_OFF_W-1:0] ftqOffset_t;

  typedef struct packed {
    robIdx_t    robIdx;
    logic [15:0] cause;
    ftqIdx_t    ftqIdx;
    ftqOffset_t ftqOffset;
  } excRecord_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FLUSH, ST_TRAP} trap_arb_state_t;

  // The flipped bit marks a wrap of the circular ROB, which inverts index order.
  function automatic logic is_older(robIdx_t a, robIdx_t b);
    return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction
endpackage

// File: rtl/trap_oldest_select.sv
// trap_oldest_select: picks the oldest valid exception report; lowest port wins ties.
module trap_oldest_select
  import trap_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                       vld_i [NUM_PORTS],
  input  excRecord_t                 rec_i [NUM_PORTS],
  output logic                       vld_o,
  output excRecord_t                 rec_o
);
  always_comb begin
    vld_o = 1'b0;
    rec_o = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (vld_i[p] && (!vld_o || is_older(rec_i[p].robIdx, rec_o.robIdx))) begin
        vld_o = 1'b1;
        rec_o = rec_i[p];
      end
  end
endmodule

// File: rtl/trap_arbiter.sv
// trap_arbiter: tracks the oldest exception, squashes the backend and raises a trap at the ROB head.
module trap_arbiter
  import trap_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic       [NUM_PORTS-1:0]         i_exc_vld,
  input  robIdx_t    [NUM_PORTS-1:0]         i_exc_robIdx,
  input  logic       [NUM_PORTS-1:0][15:0]   i_exc_cause,
  input  ftqIdx_t    [NUM_PORTS-1:0]         i_exc_ftqIdx,
  input  ftqOffset_t [NUM_PORTS-1:0]         i_exc_ftqOffset,
  input  logic                               i_bsq_vld,
  input  robIdx_t                            i_bsq_robIdx,
  input  logic                               i_head_vld,
  input  robIdx_t                            i_head_robIdx,
  input  logic                               i_irq_vld,
  input  logic       [15:0]                  i_irq_cause,
  input  logic                               i_trap_ack,
  output logic                               o_stall_commit,
  output logic                               o_squash,
  output logic                               o_trap_vld,
  output logic                               o_trap_is_irq,
  output logic       [15:0]                  o_trap_cause,
  output robIdx_t                            o_trap_robIdx,
  output ftqIdx_t                            o_trap_ftqIdx,
  output ftqOffset_t                         o_trap_ftqOffset
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  trap_arb_state_t state_q, state_d;
  excRecord_t      rec_q, rec_d, cand;
  logic            rec_vld_q, rec_vld_d, is_irq_q, is_irq_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            port_vld [NUM_PORTS];
  excRecord_t      port_rec [NUM_PORTS];
  logic            cand_vld, head_hit, rec_live;

  // Reports younger than a same-cycle mispredict are already dead.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_vld[g] = i_exc_vld[g] && !(i_bsq_vld && is_older(i_bsq_robIdx, i_exc_robIdx[g]));
    assign port_rec[g] = '{robIdx: i_exc_robIdx[g], cause: i_exc_cause[g],
                           ftqIdx: i_exc_ftqIdx[g], ftqOffset: i_exc_ftqOffset[g]};
  end

  trap_oldest_select #(.NUM_PORTS(NUM_PORTS)) u_sel (
    .vld_i (port_vld),
    .rec_i (port_rec),
    .vld_o (cand_vld),
    .rec_o (cand)
  );

  assign head_hit = i_head_vld && (i_head_robIdx == rec_q.robIdx);
  assign rec_live = rec_vld_q && !(i_bsq_vld && is_older(i_bsq_robIdx, rec_q.robIdx));

  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    rec_vld_d = rec_vld_q;
    is_irq_d  = is_irq_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE:
        if (cand_vld) begin
          rec_d     = cand;
          rec_vld_d = 1'b1;
          is_irq_d  = 1'b0;
          state_d   = ST_PEND;
        end else if (i_irq_vld && i_head_vld) begin
          rec_d     = '{robIdx: i_head_robIdx, cause: i_irq_cause, ftqIdx: '0, ftqOffset: '0};
          rec_vld_d = 1'b1;
          is_irq_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_FLUSH;
        end
      ST_PEND:
        if (head_hit) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else if (cand_vld && (!rec_live || is_older(cand.robIdx, rec_q.robIdx))) begin
          rec_d = cand;
        end else if (!rec_live) begin
          rec_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      ST_FLUSH:
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      ST_TRAP:
        if (i_trap_ack) begin
          rec_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      rec_vld_q <= 1'b0;
      is_irq_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      rec_vld_q <= rec_vld_d;
      is_irq_q  <= is_irq_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_squash         = state_q == ST_FLUSH;
  assign o_trap_vld       = state_q == ST_TRAP;
  assign o_stall_commit   = o_squash || o_trap_vld || (state_q == ST_PEND && head_hit);
  assign o_trap_is_irq    = o_trap_vld && is_irq_q;
  assign o_trap_cause     = o_trap_vld ? rec_q.cause : '0;
  assign o_trap_robIdx    = o_trap_vld ? rec_q.robIdx : '0;
  assign o_trap_ftqIdx    = o_trap_vld ? rec_q.ftqIdx : '0;
  assign o_trap_ftqOffset = o_trap_vld ? rec_q.ftqOffset : '0;
endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: directed scenarios plus random traffic checked against a circular-age reference model.
module tb_trap_arbiter;
  import trap_arbiter_pkg::*;
  localparam int NP = 4;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic       [NP-1:0]       exc_vld;
  robIdx_t    [NP-1:0]       exc_rob;
  logic       [NP-1:0][15:0] exc_cause;
  ftqIdx_t    [NP-1:0]       exc_ftq;
  ftqOffset_t [NP-1:0]       exc_off;
  logic bsq_vld, head_vld, irq_vld, ack;
  robIdx_t bsq_rob, head_rob;
  logic [15:0] irq_cause;
  logic o_stall_commit, o_squash, o_trap_vld, o_trap_is_irq;
  logic [15:0] o_trap_cause;
  robIdx_t o_trap_robIdx;
  ftqIdx_t o_trap_ftqIdx;
  ftqOffset_t o_trap_ftqOffset;

  int n_cmp = 0;
  int n_err = 0;

  bit m_vld, m_irq, m_trap;
  int m_sq;
  logic [5:0] m_rob;
  logic [15:0] m_cause;
  logic [5:0] m_ftq;
  logic [3:0] m_off;

  trap_arbiter #(.NUM_PORTS(NP), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .i_exc_vld(exc_vld), .i_exc_robIdx(exc_rob), .i_exc_cause(exc_cause),
    .i_exc_ftqIdx(exc_ftq), .i_exc_ftqOffset(exc_off),
    .i_bsq_vld(bsq_vld), .i_bsq_robIdx(bsq_rob),
    .i_head_vld(head_vld), .i_head_robIdx(head_rob),
    .i_irq_vld(irq_vld), .i_irq_cause(irq_cause), .i_trap_ack(ack),
    .o_stall_commit(o_stall_commit), .o_squash(o_squash), .o_trap_vld(o_trap_vld),
    .o_trap_is_irq(o_trap_is_irq), .o_trap_cause(o_trap_cause), .o_trap_robIdx(o_trap_robIdx),
    .o_trap_ftqIdx(o_trap_ftqIdx), .o_trap_ftqOffset(o_trap_ftqOffset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic robIdx_t r(input logic [5:0] v);
    return robIdx_t'(v);
  endfunction

  // Circular distance: a is older when b lies 1..31 slots ahead of a.
  function automatic bit older(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    d = b - a;
    return d != 6'd0 && d < 6'd32;
  endfunction

  task automatic m_reset();
    m_vld = 0; m_irq = 0; m_trap = 0; m_sq = 0;
    m_rob = '0; m_cause = '0; m_ftq = '0; m_off = '0;
  endtask

  task automatic m_update();
    bit cv, was_idle;
    int cp;
    cv = 0; cp = 0; was_idle = !m_vld;
    if (m_trap) begin
      if (ack) begin m_trap = 0; m_vld = 0; end
    end else if (m_sq > 0) begin
      m_sq--;
      if (m_sq == 0) m_trap = 1;
    end else begin
      for (int p = 0; p < NP; p++)
        if (exc_vld[p] && !(bsq_vld && older(bsq_rob, exc_rob[p])) && (!cv || older(exc_rob[p], exc_rob[cp]))) begin
          cv = 1; cp = p;
        end
      if (!was_idle && head_vld && 6'(head_rob) == m_rob) m_sq = FC;
      else begin
        if (m_vld && bsq_vld && older(bsq_rob, m_rob)) m_vld = 0;
        if (cv && (!m_vld || older(exc_rob[cp], m_rob))) begin
          m_vld = 1; m_irq = 0; m_rob = exc_rob[cp]; m_cause = exc_cause[cp];
          m_ftq = exc_ftq[cp]; m_off = exc_off[cp];
        end else if (was_idle && irq_vld && head_vld) begin
          m_vld = 1; m_irq = 1; m_rob = head_rob; m_cause = irq_cause;
          m_ftq = '0; m_off = '0; m_sq = FC;
        end
      end
    end
  endtask

  task automatic step();
    bit e_sq, e_stall;
    #1;
    e_sq = m_sq > 0;
    e_stall = e_sq || m_trap || (m_vld && !e_sq && !m_trap && head_vld && 6'(head_rob) == m_rob);
    chk("ctrl", {o_stall_commit, o_squash, o_trap_vld}, {e_stall, e_sq, m_trap});
    chk("fields", {o_trap_is_irq, o_trap_cause, o_trap_robIdx, o_trap_ftqIdx, o_trap_ftqOffset},
        m_trap ? {m_irq, m_cause, m_rob, m_ftq, m_off} : 33'd0);
    @(posedge clk);
    if (rst) m_update(); else m_reset();
    @(negedge clk);
  endtask

  task automatic clr();
    exc_vld = '0; exc_rob = '0; exc_cause = '0; exc_ftq = '0; exc_off = '0;
    bsq_vld = 0; bsq_rob = '0; head_vld = 0; head_rob = '0;
    irq_vld = 0; irq_cause = '0; ack = 0;
  endtask

  initial begin
    logic [5:0] base;
    clr();
    m_reset();
    @(negedge clk);
    step();
    rst = 1'b1;
    // oldest of two same-cycle reports traps, with its own cause
    exc_vld[1] = 1; exc_rob[1] = r(6'd5); exc_cause[1] = 16'h11;
    exc_vld[3] = 1; exc_rob[3] = r(6'd2); exc_cause[3] = 16'h33; exc_ftq[3] = 6'h2a; exc_off[3] = 4'h5;
    step();
    clr(); head_vld = 1; head_rob = r(6'd2);
    step();
    clr();
    chk("t1_squash1", o_squash, 1);
    step();
    chk("t1_squash2", o_squash, 1);
    step();
    chk("t1_trap", {o_trap_vld, o_trap_cause, o_trap_robIdx, o_trap_ftqIdx, o_trap_ftqOffset},
        {1'b1, 16'h33, 6'd2, 6'h2a, 4'h5});
    ack = 1; step(); ack = 0;
    chk("t1_idle", {o_trap_vld, o_stall_commit}, 0);
    // wrapped index {0,30} is older than {1,1}
    exc_vld[0] = 1; exc_rob[0] = r(6'b1_00001); exc_cause[0] = 16'd1; step();
    exc_rob[0] = r(6'd30); exc_cause[0] = 16'd2; step();
    clr(); head_vld = 1; head_rob = r(6'd30); step();
    clr(); step(); step();
    chk("t2_wrap", {o_trap_vld, o_trap_robIdx, o_trap_cause}, {1'b1, 6'd30, 16'd2});
    ack = 1; step(); clr();
    // mispredict kills the record and the same-cycle younger report
    exc_vld[0] = 1; exc_rob[0] = r(6'd9); exc_cause[0] = 16'd9; step();
    clr(); bsq_vld = 1; bsq_rob = r(6'd4); exc_vld[1] = 1; exc_rob[1] = r(6'd6); step();
    clr(); head_vld = 1; head_rob = r(6'd9); #1;
    chk("t3_stall9", o_stall_commit, 0);
    head_rob = r(6'd6); #1;
    chk("t3_stall6", o_stall_commit, 0);
    step(); step();
    chk("t3_nosquash", o_squash, 0);
    // interrupt at head while idle
    clr(); irq_vld = 1; irq_cause = 16'd7; head_vld = 1; head_rob = r(6'd3); step();
    clr(); step(); step();
    chk("t4_irq", {o_trap_vld, o_trap_is_irq, o_trap_cause, o_trap_robIdx, o_trap_ftqIdx, o_trap_ftqOffset},
        {2'b11, 16'd7, 6'd3, 10'd0});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold", {o_stall_commit, o_trap_vld}, 2'b11);
    end
    ack = 1; step(); clr();
    // pending exception outranks an interrupt
    exc_vld[2] = 1; exc_rob[2] = r(6'd4); exc_cause[2] = 16'd5; step();
    clr(); irq_vld = 1; irq_cause = 16'd3; head_vld = 1; head_rob = r(6'd1); step(); step();
    chk("t5_noirq", o_squash, 0);
    head_rob = r(6'd4); step(); step(); step();
    chk("t5_exc", {o_trap_vld, o_trap_is_irq, o_trap_cause, o_trap_robIdx}, {2'b10, 16'd5, 6'd4});
    clr(); ack = 1; step(); clr();
    // asynchronous reset in the middle of the flush
    irq_vld = 1; irq_cause = 16'd11; head_vld = 1; head_rob = r(6'd8); step();
    clr();
    chk("t6_flush", o_squash, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst", {o_stall_commit, o_squash, o_trap_vld, o_trap_is_irq, o_trap_cause,
                   o_trap_robIdx, o_trap_ftqIdx, o_trap_ftqOffset}, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1; head_vld = 1; head_rob = r(6'd8);
    step(); step();
    chk("t6_idle", {o_stall_commit, o_squash}, 0);
    clr();
    base = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) base = 6'($urandom);
      exc_vld = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      for (int p = 0; p < NP; p++) begin
        exc_rob[p] = r(6'(base + 6'($urandom_range(0, 15))));
        exc_cause[p] = 16'($urandom);
        exc_ftq[p] = 6'($urandom);
        exc_off[p] = 4'($urandom);
      end
      bsq_vld = $urandom_range(0, 7) == 0;
      bsq_rob = r(6'(base + 6'($urandom_range(0, 15))));
      head_vld = $urandom_range(0, 3) != 0;
      head_rob = ($urandom_range(0, 1) == 1) ? r(m_rob) : r(6'(base + 6'($urandom_range(0, 15))));
      irq_vld = $urandom_range(0, 5) == 0;
      irq_cause = 16'($urandom_range(0, 15));
      ack = $urandom_range(0, 2) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
